// File: rtl/vs_dict_proc_engine.sv
// Dictionary processing engine: streams atom/signal inner products
// and applies residual updates y <- y - s*d_j over 1-cycle sync RAMs.

package vs_dict_proc_pkg;
  localparam int FP_DATA_BUS_WIDTH = 32;

  typedef enum logic [2:0] {
    LOAD_SENSING_MATRIX            = 3'd0,
    LOAD_ATOM_SCALE_FACTOR         = 3'd1,
    COMPUTE_INNER_PRODUCTS         = 3'd2,
    SUBTRACT_SCALED_ATOM_FROM_DATA = 3'd3,
    COMPUTE_APPROXIMATION          = 3'd4
  } vs_dict_proc_command_t;
endpackage

module vs_dict_proc_engine
  import vs_dict_proc_pkg::*;
#(
  parameter int SIGNAL_SIZE           = 16,
  parameter int DICTIONARY_SIZE       = 64,
  parameter int FP_Q                  = 15,
  parameter int SIGNAL_ADDR_WIDTH     = 8,
  parameter int DICTIONARY_ADDR_WIDTH =
    $clog2(SIGNAL_SIZE * DICTIONARY_SIZE)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  vs_dict_proc_command_t            cmd,
  input  logic [31:0]                      cmd_arg,
  output logic [DICTIONARY_ADDR_WIDTH-1:0] dict_rd_addr,
  input  logic [FP_DATA_BUS_WIDTH-1:0]     dict_rd_data,
  output logic [SIGNAL_ADDR_WIDTH-1:0]     y_rd_addr,
  input  logic [FP_DATA_BUS_WIDTH-1:0]     y_rd_data,
  output logic                             y_wr_en,
  output logic [SIGNAL_ADDR_WIDTH-1:0]     y_wr_addr,
  output logic [31:0]                      y_wr_data,
  output logic                             ip_valid,
  output logic [15:0]                      ip_index,
  output logic [31:0]                      ip_data,
  output logic                             done,
  output logic                             err
);

  localparam int M   = SIGNAL_SIZE;
  localparam int N   = DICTIONARY_SIZE;
  localparam int NM  = M * N;
  localparam int CW  = $clog2(NM + 1);
  localparam int AW  = 64 + $clog2(M) + 1;
  localparam int DAW = DICTIONARY_ADDR_WIDTH;
  localparam int SAW = SIGNAL_ADDR_WIDTH;

  localparam logic signed [AW-1:0] SAT_MAX =
    {{(AW-31){1'b0}}, {31{1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN =
    {{(AW-31){1'b1}}, {31{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_IP,
    S_SUB,
    S_FIN
  } state_e;

  state_e state_q, state_d;

  logic [31:0]    scale_q, scale_d;
  logic           err_q, err_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DAW-1:0] da_q, da_d;
  logic [SAW-1:0] ya_q, ya_d;
  logic [15:0]    j_q, j_d;

  logic           p_vld_q, p_vld_d;
  logic           p_first_q, p_first_d;
  logic           p_last_q, p_last_d;
  logic [15:0]    p_j_q, p_j_d;
  logic [SAW-1:0] p_i_q, p_i_d;

  logic signed [AW-1:0] acc_q, acc_d;

  logic           ipv_q, ipv_d;
  logic [15:0]    ipi_q, ipi_d;
  logic [31:0]    ipd_q, ipd_d;
  logic           we_q, we_d;
  logic [SAW-1:0] wa_q, wa_d;
  logic [31:0]    wd_q, wd_d;

  logic signed [63:0] d_ext, y_ext, s_ext;
  logic signed [63:0] prod, sprod;
  logic signed [AW-1:0] acc_sum, acc_sh;
  logic [31:0] sat_val, sub_term;
  logic        issue, ya_last, idx_bad;

  assign d_ext = {{32{dict_rd_data[31]}}, dict_rd_data};
  assign y_ext = {{32{y_rd_data[31]}}, y_rd_data};
  assign s_ext = {{32{scale_q[31]}}, scale_q};
  assign prod  = d_ext * y_ext;
  assign sprod = s_ext * d_ext;

  assign acc_sum = (p_first_q ? '0 : acc_q)
                 + {{(AW-64){prod[63]}}, prod};
  assign acc_sh  = acc_sum >>> FP_Q;
  assign sub_term = 32'(sprod >>> FP_Q);

  always_comb begin
    sat_val = acc_sh[31:0];
    if (acc_sh > SAT_MAX) begin
      sat_val = 32'h7FFF_FFFF;
    end else if (acc_sh < SAT_MIN) begin
      sat_val = 32'h8000_0000;
    end
  end

  assign ya_last = (ya_q == SAW'(M - 1));
  assign idx_bad = (cmd_arg[15:0] >= 16'(N));
  assign issue   = (state_q == S_IP  && cnt_q < CW'(NM)) ||
                   (state_q == S_SUB && cnt_q < CW'(M));

  always_comb begin
    state_d   = state_q;
    scale_d   = scale_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    da_d      = da_q;
    ya_d      = ya_q;
    j_d       = j_q;
    p_vld_d   = 1'b0;
    p_first_d = p_first_q;
    p_last_d  = p_last_q;
    p_j_d     = p_j_q;
    p_i_d     = p_i_q;
    acc_d     = acc_q;
    ipv_d     = 1'b0;
    ipi_d     = ipi_q;
    ipd_d     = ipd_q;
    we_d      = 1'b0;
    wa_d      = wa_q;
    wd_d      = wd_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          err_d = 1'b0;
          cnt_d = '0;
          da_d  = '0;
          ya_d  = '0;
          j_d   = '0;
          unique case (cmd)
            LOAD_SENSING_MATRIX: begin
              state_d = S_FIN;
            end
            LOAD_ATOM_SCALE_FACTOR: begin
              scale_d = cmd_arg;
              state_d = S_FIN;
            end
            COMPUTE_INNER_PRODUCTS: begin
              state_d = S_IP;
            end
            SUBTRACT_SCALED_ATOM_FROM_DATA: begin
              if (idx_bad) begin
                err_d   = 1'b1;
                state_d = S_FIN;
              end else begin
                da_d    = DAW'(32'(cmd_arg[15:0]) * 32'(M));
                state_d = S_SUB;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = S_FIN;
            end
          endcase
        end
      end
      S_IP: begin
        if (cnt_q == CW'(NM)) state_d = S_FIN;
      end
      S_SUB: begin
        if (cnt_q == CW'(M)) state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Issue stage: one dictionary/signal address pair per cycle
    if (issue) begin
      cnt_d     = cnt_q + 1'b1;
      da_d      = da_q + 1'b1;
      ya_d      = ya_last ? '0 : ya_q + 1'b1;
      j_d       = ya_last ? j_q + 1'b1 : j_q;
      p_vld_d   = 1'b1;
      p_first_d = (ya_q == '0);
      p_last_d  = ya_last;
      p_j_d     = j_q;
      p_i_d     = ya_q;
    end

    if (p_vld_q && state_q == S_IP) begin
      acc_d = acc_sum;
      if (p_last_q) begin
        ipv_d = 1'b1;
        ipi_d = p_j_q;
        ipd_d = sat_val;
      end
    end

    if (p_vld_q && state_q == S_SUB) begin
      we_d = 1'b1;
      wa_d = p_i_q;
      wd_d = y_rd_data - sub_term;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      scale_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      da_q      <= '0;
      ya_q      <= '0;
      j_q       <= '0;
      p_vld_q   <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
      p_j_q     <= '0;
      p_i_q     <= '0;
      acc_q     <= '0;
      ipv_q     <= 1'b0;
      ipi_q     <= '0;
      ipd_q     <= '0;
      we_q      <= 1'b0;
      wa_q      <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      scale_q   <= scale_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      da_q      <= da_d;
      ya_q      <= ya_d;
      j_q       <= j_d;
      p_vld_q   <= p_vld_d;
      p_first_q <= p_first_d;
      p_last_q  <= p_last_d;
      p_j_q     <= p_j_d;
      p_i_q     <= p_i_d;
      acc_q     <= acc_d;
      ipv_q     <= ipv_d;
      ipi_q     <= ipi_d;
      ipd_q     <= ipd_d;
      we_q      <= we_d;
      wa_q      <= wa_d;
      wd_q      <= wd_d;
    end
  end

  assign cmd_ready    = (state_q == S_IDLE);
  assign done         = (state_q == S_FIN);
  assign err          = (state_q == S_FIN) && err_q;
  assign dict_rd_addr = da_q;
  assign y_rd_addr    = ya_q;
  assign y_wr_en      = we_q;
  assign y_wr_addr    = wa_q;
  assign y_wr_data    = wd_q;
  assign ip_valid     = ipv_q;
  assign ip_index     = ipi_q;
  assign ip_data      = ipd_q;

endmodule

// File: tb/tb_vs_dict_proc_engine.sv
// Bench for vs_dict_proc_engine: sync RAM models plus a plain
// arithmetic reference for inner products and residual updates.

module tb_vs_dict_proc_engine;
  import vs_dict_proc_pkg::*;

  localparam int M   = 16;
  localparam int N   = 64;
  localparam int NM  = M * N;
  localparam int Q   = 15;
  localparam int DAW = $clog2(NM);

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  cmd_valid = 1'b0;
  logic                  cmd_ready;
  vs_dict_proc_command_t cmd = LOAD_SENSING_MATRIX;
  logic [31:0]           cmd_arg = '0;
  logic [DAW-1:0]        dict_rd_addr;
  logic [31:0]           dict_rd_data = '0;
  logic [7:0]            y_rd_addr;
  logic [31:0]           y_rd_data = '0;
  logic                  y_wr_en;
  logic [7:0]            y_wr_addr;
  logic [31:0]           y_wr_data;
  logic                  ip_valid;
  logic [15:0]           ip_index;
  logic [31:0]           ip_data;
  logic                  done;
  logic                  err;

  logic [31:0] d_mem [NM];
  logic [31:0] y_mem [M];
  logic [31:0] scale_m = '0;

  int errors = 0;
  int checks = 0;

  vs_dict_proc_engine dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd          (cmd),
    .cmd_arg      (cmd_arg),
    .dict_rd_addr (dict_rd_addr),
    .dict_rd_data (dict_rd_data),
    .y_rd_addr    (y_rd_addr),
    .y_rd_data    (y_rd_data),
    .y_wr_en      (y_wr_en),
    .y_wr_addr    (y_wr_addr),
    .y_wr_data    (y_wr_data),
    .ip_valid     (ip_valid),
    .ip_index     (ip_index),
    .ip_data      (ip_data),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    dict_rd_data <= d_mem[dict_rd_addr];
    y_rd_data    <= y_mem[y_rd_addr[3:0]];
    if (y_wr_en) y_mem[y_wr_addr[3:0]] = y_wr_data;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [31:0] ref_ip(input int j);
    logic signed [95:0] sum;
    logic signed [95:0] sh;
    sum = '0;
    for (int i = 0; i < M; i++)
      sum = sum + $signed(d_mem[j*M+i]) * $signed(y_mem[i]);
    sh = sum >>> Q;
    if (sh > 96'sh7FFFFFFF) return 32'h7FFFFFFF;
    if (sh < -96'sh80000000) return 32'h80000000;
    return 32'(sh);
  endfunction

  function automatic logic [31:0] ref_sub(
    input logic [31:0] yv, input logic [31:0] dv, input logic [31:0] s);
    longint p;
    p = longint'($signed(s)) * longint'($signed(dv));
    p = p >>> Q;
    return yv - 32'(p);
  endfunction

  task automatic send(input vs_dict_proc_command_t c,
                      input logic [31:0] a);
    int n;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept: cmd_ready=%0b required 1", cmd_ready);
    end
    cmd = c;
    cmd_arg = a;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ip_valid, done, err, y_wr_en} !== 4'b0 ||
        {dict_rd_addr, y_rd_addr, y_wr_addr} !== '0 ||
        {y_wr_data, ip_data, ip_index} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: v=%0b d=%0b e=%0b we=%0b da=%0h ya=%0h wa=%0h wd=%0h ipd=%0h ipi=%0h required all 0",
               ip_valid, done, err, y_wr_en, dict_rd_addr, y_rd_addr,
               y_wr_addr, y_wr_data, ip_data, ip_index);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: cmd_ready=%0b required 1", cmd_ready);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if ({ip_valid, done, err, y_wr_en, ip_data, y_wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_idle: v=%0b d=%0b e=%0b we=%0b required 0",
               ip_valid, done, err, y_wr_en);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready2: cmd_ready=%0b required 1", cmd_ready);
    end
  endtask

  task automatic do_load(input vs_dict_proc_command_t c,
                         input logic [31:0] a);
    send(c, a);
    checks++;
    if (done !== 1'b1 || err !== 1'b0 || y_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL load_done: done=%0b err=%0b we=%0b required 1 0 0",
               done, err, y_wr_en);
    end
    if (c == LOAD_ATOM_SCALE_FACTOR) scale_m = a;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL load_ready: ready=%0b done=%0b required 1 0",
               cmd_ready, done);
    end
  endtask

  task automatic do_sub(input int j);
    logic [31:0] exp_y [M];
    bit ev;
    for (int i = 0; i < M; i++)
      exp_y[i] = ref_sub(y_mem[i], d_mem[j*M+i], scale_m);
    send(SUBTRACT_SCALED_ATOM_FROM_DATA, 32'(j));
    for (int c = 0; c <= M + 1; c++) begin
      if (c > 0) @(negedge clk);
      if (c < M) begin
        checks++;
        if (dict_rd_addr !== DAW'(j*M+c) || y_rd_addr !== 8'(c)) begin
          errors++;
          $display("FAIL sub_addr c=%0d: da=%0d ya=%0d required %0d %0d",
                   c, dict_rd_addr, y_rd_addr, j*M+c, c);
        end
      end
      ev = (c >= 2);
      checks++;
      if (y_wr_en !== ev) begin
        errors++;
        $display("FAIL sub_we c=%0d: we=%0b required %0b", c, y_wr_en, ev);
      end
      if (ev) begin
        checks++;
        if (y_wr_addr !== 8'(c-2) || y_wr_data !== exp_y[c-2]) begin
          errors++;
          $display("FAIL sub_wr c=%0d: addr=%0d data=%08h required %0d %08h",
                   c, y_wr_addr, y_wr_data, c-2, exp_y[c-2]);
        end
      end
      checks++;
      if ({done, err} !== {(c == M + 1), 1'b0}) begin
        errors++;
        $display("FAIL sub_done c=%0d: done=%0b err=%0b required %0b 0",
                 c, done, err, (c == M + 1));
      end
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || y_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL sub_ready: ready=%0b we=%0b required 1 0",
               cmd_ready, y_wr_en);
    end
    for (int i = 0; i < M; i++) y_mem[i] = exp_y[i];
  endtask

  task automatic do_ip(input string tag);
    logic [31:0] exp_ip [N];
    bit ev;
    int jj;
    for (int j = 0; j < N; j++) exp_ip[j] = ref_ip(j);
    send(COMPUTE_INNER_PRODUCTS, 32'h0);
    for (int c = 0; c <= NM + 1; c++) begin
      if (c > 0) @(negedge clk);
      if (c < NM) begin
        checks++;
        if (dict_rd_addr !== DAW'(c) || y_rd_addr !== 8'(c % M)) begin
          errors++;
          $display("FAIL %s_addr c=%0d: da=%0d ya=%0d required %0d %0d",
                   tag, c, dict_rd_addr, y_rd_addr, c, c % M);
        end
      end
      ev = (c > M) && ((c - 1) % M == 0);
      checks++;
      if (ip_valid !== ev) begin
        errors++;
        $display("FAIL %s_valid c=%0d: ip_valid=%0b required %0b",
                 tag, c, ip_valid, ev);
      end
      if (ev) begin
        jj = (c - 1) / M - 1;
        checks++;
        if (ip_index !== 16'(jj) || ip_data !== exp_ip[jj]) begin
          errors++;
          $display("FAIL %s_data c=%0d: idx=%0d data=%08h required %0d %08h",
                   tag, c, ip_index, ip_data, jj, exp_ip[jj]);
        end
      end
      checks++;
      if ({done, err} !== {(c == NM + 1), 1'b0}) begin
        errors++;
        $display("FAIL %s_done c=%0d: done=%0b err=%0b required %0b 0",
                 tag, c, done, err, (c == NM + 1));
      end
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || ip_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready: ready=%0b v=%0b done=%0b required 1 0 0",
               tag, cmd_ready, ip_valid, done);
    end
  endtask

  task automatic do_reject(input vs_dict_proc_command_t c,
                           input logic [31:0] a);
    send(c, a);
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || y_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reject_t0: done=%0b err=%0b we=%0b required 1 1 0",
               done, err, y_wr_en);
    end
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 ||
        y_wr_en !== 1'b0) begin
      errors++;
      $display("FAIL reject_next: ready=%0b done=%0b err=%0b we=%0b required 1 0 0 0",
               cmd_ready, done, err, y_wr_en);
    end
  endtask

  task automatic test_scale_subtract();
    for (int i = 0; i < NM; i++) d_mem[i] = 32'(i * 7);
    for (int i = 0; i < M; i++) begin
      d_mem[2*M+i] = 32'h8000;
      y_mem[i] = 32'h18000;
    end
    do_load(LOAD_ATOM_SCALE_FACTOR, 32'h4000);
    do_sub(2);
    checks++;
    if (y_mem[5] !== 32'h14000) begin
      errors++;
      $display("FAIL sub_model: y5=%08h required 00014000", y_mem[5]);
    end
  endtask

  task automatic test_inner_products();
    for (int i = 0; i < M; i++) y_mem[i] = 32'h8000;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < M; i++) d_mem[j*M+i] = 32'(j * 32'h1000);
    checks++;
    if (ref_ip(37) !== 32'(37 * 32'h10000)) begin
      errors++;
      $display("FAIL ip_model: got %08h required %08h",
               ref_ip(37), 37 * 32'h10000);
    end
    do_ip("ip");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < M; i++) y_mem[i] = 32'h7FFFFFFF;
    for (int i = 0; i < NM; i++) d_mem[i] = 32'h7FFFFFFF;
    do_ip("satpos");
    for (int i = 0; i < NM; i++) d_mem[i] = 32'h80000000;
    do_ip("satneg");
  endtask

  task automatic test_random();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < M; i++)
        y_mem[i] = 32'($urandom_range(0, 32'h1FFFFF)) - 32'h100000;
      for (int i = 0; i < NM; i++)
        d_mem[i] = 32'($urandom_range(0, 32'h1FFFFF)) - 32'h100000;
      do_ip("rand");
      for (int i = 0; i < M; i++) y_mem[i] = $urandom;
      for (int i = 0; i < NM; i++) d_mem[i] = $urandom;
      do_load(LOAD_ATOM_SCALE_FACTOR, $urandom);
      do_sub($urandom_range(0, N - 1));
      do_load(LOAD_SENSING_MATRIX, $urandom);
      do_sub(N - 1);
    end
  endtask

  task automatic test_reject();
    do_reject(COMPUTE_APPROXIMATION, 32'h0);
    do_reject(SUBTRACT_SCALED_ATOM_FROM_DATA, 32'd64);
    do_reject(SUBTRACT_SCALED_ATOM_FROM_DATA, 32'h0000FFFF);
  endtask

  task automatic test_abort();
    bit seen;
    for (int i = 0; i < M; i++) y_mem[i] = 32'h8000;
    for (int i = 0; i < NM; i++) d_mem[i] = 32'h1000;
    send(COMPUTE_INNER_PRODUCTS, 32'h0);
    repeat (100) @(negedge clk);
    checks++;
    if (dict_rd_addr !== DAW'(100)) begin
      errors++;
      $display("FAIL abort_point: da=%0d required 100", dict_rd_addr);
    end
    reset = 1'b1;
    #1;
    seen = 1'b0;
    repeat (3) begin
      if (ip_valid || done || y_wr_en || err) seen = 1'b1;
      @(negedge clk);
    end
    reset = 1'b0;
    scale_m = '0;
    repeat (40) begin
      if (ip_valid || done || y_wr_en || err || !cmd_ready) seen = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_quiet: activity seen=%0b required 0", seen);
    end
    for (int i = 0; i < M; i++) y_mem[i] = $urandom;
    for (int i = 0; i < NM; i++) d_mem[i] = $urandom;
    do_sub(9);
    do_load(LOAD_ATOM_SCALE_FACTOR, 32'hFFFF_4000);
    do_sub(9);
  endtask

  initial begin
    test_reset();
    test_scale_subtract();
    test_inner_products();
    test_saturation();
    test_reject();
    test_random();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vs_dict_proc_engine.md
# vs_dict_proc_engine

Command responder for the pursuit controller. It accepts `vs_dict_proc_command_t` commands over a valid/ready handshake and executes them against the signal RAM (y) and dictionary RAM through 1-cycle-latency sync RAM ports. It streams dictionary–signal inner products back to the controller and performs residual update y ← y − s·d_j. All arithmetic is (15, 32) fixed point.

## Interface
- SIGNAL_SIZE, SIGNAL_SIZE_DEFAULT (16): M, elements per atom and per signal.
- DICTIONARY_SIZE, DICTIONARY_SIZE_DEFAULT (64): N, number of atoms.
- FP_Q, FP_Q_DEFAULT (15): fractional bits.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine idle, can accept a command.
- cmd  in  vs_dict_proc_command_t  command opcode.
- cmd_arg  in  32  scale factor (fp_32_t) for LOAD_ATOM_SCALE_FACTOR; atom index in [15:0] for SUBTRACT_SCALED_ATOM_FROM_DATA.
- dict_rd_addr  out  DICTIONARY_ADDR_WIDTH  dictionary read address. Layout is column-major: element i of atom j is at address j·M+i.
- dict_rd_data  in  FP_DATA_BUS_WIDTH  dictionary data, valid 1 cycle after the address.
- y_rd_addr  out  SIGNAL_ADDR_WIDTH  signal read address.
- y_rd_data  in  FP_DATA_BUS_WIDTH  signal data, valid 1 cycle after the address.
- y_wr_en, y_wr_addr, y_wr_data  out  1/8/32  signal write port.
- ip_valid  out  1  inner-product result strobe.
- ip_index  out  16  atom index of the result.
- ip_data  out  32  inner product (fp_32_t, saturated).
- done  out  1  one-cycle pulse at command completion.
- err  out  1  one-cycle pulse with done when the command is rejected.

## Operation
- FSM states:
  - IDLE: cmd_ready = 1.
  - IP: inner products.
  - SUB: residual update.
  - FIN: single cycle, done pulse.
- A command is accepted on cmd_valid && cmd_ready. Every other state holds cmd_ready = 0. cmd and cmd_arg are captured at acceptance.
- LOAD_SENSING_MATRIX: no memory activity. → FIN. The matrix is loaded externally.
- LOAD_ATOM_SCALE_FACTOR: scale_reg ← cmd_arg. → FIN.
- COMPUTE_INNER_PRODUCTS: for j = 0..N−1, ip_j = sat32(Σ_i (D[j·M+i]·y[i]) >>> FP_Q).
  - Each product is a signed 64-bit value.
  - The accumulator is 64+$clog2(M)+1 bits signed, cleared at each atom start.
  - The arithmetic right shift is applied to the final sum.
  - Saturation clamps to [0x80000000, 0x7FFFFFFF].
  - Reads stream with no bubble between atoms; y is re-read for every atom.
- SUBTRACT_SCALED_ATOM_FROM_DATA with atom j = cmd_arg[15:0]: for i = 0..M−1, y[i] ← y[i] − low32((scale_reg·D[j·M+i]) >>> FP_Q).
  - The subtraction wraps modulo 2^32.
  - Each y[i] is read once and written once, so there is no read-after-write hazard.
- COMPUTE_APPROXIMATION (not handled by this block), or atom index ≥ N: → FIN with err = 1. There is no RAM access and no y write.
- scale_reg persists across commands. Reset value is 0.

## Timing
- Let t0 be the cycle after acceptance.
- IP:
  - Global element e = j·M+i: dict_rd_addr = e and y_rd_addr = i in cycle t0+e.
  - Data is accumulated at the end of cycle t0+e+1.
  - ip_valid/ip_index = j/ip_data are registered and high for exactly one cycle at t0+(j+1)·M+1.
  - done pulses in the same cycle as the last ip_valid (t0+N·M+1).
- SUB:
  - Addresses are issued in t0+i.
  - The product is registered at t0+i+1.
  - y_wr_en = 1 with y_wr_addr = i at t0+i+2.
  - done pulses in the same cycle as the final write (t0+M+1).
- LOAD_*, rejected commands: done (and err) pulse at t0.
- cmd_ready rises the cycle after done, so there is a minimum of one idle cycle between commands.
- Address outputs when not reading are don't-care; the bench checks them only in active cycles.
- Reset values (asynchronous, in force while reset = 1):
  - state IDLE, so cmd_ready = 1 after deassertion.
  - ip_valid, done, err, y_wr_en = 0.
  - all addresses, data outputs and scale_reg = 0.
  - accumulator and counters cleared.
- Reset mid-command aborts the command immediately. No further y writes occur and no done is produced.

## Test plan
- Reset: assert reset mid-idle → all outputs 0, cmd_ready = 1 the first cycle after deassertion.
- Scale + subtract:
  - LOAD_ATOM_SCALE_FACTOR arg 0x00004000 (0.5) → done at t0, err = 0.
  - SUBTRACT atom 2, with all D[32..47] = 0x8000 (1.0) and y[i] = 0x18000 (3.0) → 16 writes of 0x14000 (2.5) at t0+2..t0+17, done at t0+17.
- Inner products: y[i] = 0x8000; atom j entries = j·0x1000 → 64 strobes, ip_index j at t0+16j+17, ip_data = j·0x10000, done with index 63.
- Saturation:
  - All y and D = 0x7FFFFFFF → every ip_data = 0x7FFFFFFF.
  - All D = 0x80000000, y = 0x7FFFFFFF → every ip_data = 0x80000000.
- Rejection: COMPUTE_APPROXIMATION, and SUBTRACT with arg 64 → done and err at t0, y_wr_en never asserted, cmd_ready back next cycle.
- Abort: reset asserted during COMPUTE_INNER_PRODUCTS at element 100 → ip_valid/done 0 from reset onward. A following LOAD_ATOM_SCALE_FACTOR completes normally, and scale_reg reads back as the new value via a subsequent subtract.
